// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder: one full-adder slice is reused for WIDTH cycles, consuming
//   the operand LSBs each cycle and shifting the sum in from the top.
//
//   Ports
//     clk    in   clock, all state on rising edge
//     rst_n  in   asynchronous active-low reset
//     start  in   begin an operation (only looked at while idle)
//     a, b   in   WIDTH-bit operands, captured with the accepted start
//     cin    in   initial carry, captured with the accepted start
//     sub    in   (SERIAL_ADDER_SUB_EN only) 1 = compute a-b, captured with start
//     sum    out  registered result, valid with done and afterwards while idle
//     cout   out  registered final carry (for subtraction: 1 = no borrow)
//     busy   out  high while bits are being processed
//     done   out  one-cycle completion pulse
//
//   Optional feature: define SERIAL_ADDER_SUB_EN to add the sub input.
//
//   Timing: start sampled on edge E0, bit-cycles on E1..E(WIDTH), done is high
//   after E(WIDTH) for one cycle, back in idle one edge later.

module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;

   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic             slice_s, slice_co;
   logic             accept;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (cnt_q == CntLast) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      busy = (state_q == StRun);
      done = (state_q == StDone);
      sum  = sum_q;
      cout = cout_q;
   end

   // ---------------------------------------------------------------- datapath
   // Subtraction is a + ~b + 1, so only the loaded B value and initial carry change.
   always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
      b_load = sub ? ~b : b;
      c_load = sub ? 1'b1 : cin;
`else
      b_load = b;
      c_load = cin;
`endif
   end

   // The single full-adder slice shared by every bit position.
   always_comb begin
      slice_s  = a_q[0] ^ b_q[0] ^ carry_q;
      slice_co = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
   end

   assign accept = (state_q == StIdle) && start;

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      if (accept) begin
         a_d     = a;
         b_d     = b_load;
         carry_d = c_load;
         cnt_d   = '0;
         sum_d   = '0;
      end else if (state_q == StRun) begin
         sum_d   = {slice_s, sum_q[WIDTH-1:1]};
         a_d     = a_q >> 1;
         b_d     = b_q >> 1;
         carry_d = slice_co;
         cnt_d   = cnt_q + 1'b1;
         // cout keeps the previous result until the last bit produces the new one
         if (cnt_q == CntLast) cout_d = slice_co;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed, table-driven bench for serial_adder_ctrl at WIDTH=8.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_serial_adder_ctrl;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub;
`endif
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
   logic         done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .sum   (sum),
      .cout  (cout),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One operation. The start edge is the first counted edge, so done must be
   // seen after the 9th edge with busy high for 8 samples before it.
   // repulse_at > 0 raises start (with different operands) for one cycle mid-RUN.
   task automatic run_op(input vec_t v, input int repulse_at, input bit no_wait,
                         input string tag);
      int k;
      int busy_cnt;
      int extra;
      if (!no_wait) @(negedge clk);
      a = v.a; b = v.b; cin = v.cin; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
      sub = v.sub;
`endif
      @(negedge clk);
      start    = 1'b0;
      k        = 1;
      busy_cnt = 0;
      while (!done && k < 20) begin
         if (busy) busy_cnt++;
         if (k == repulse_at) begin
            start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check({tag, " done edge"}, k, 9);
      check({tag, " busy cycles"}, busy_cnt, 8);
      check({tag, " busy in DONE"}, busy, 0);
      check({tag, " sum"}, sum, v.exp_sum);
      check({tag, " cout"}, cout, v.exp_cout);
      @(negedge clk);
      check({tag, " done width"}, done, 0);
      check({tag, " sum held"}, sum, v.exp_sum);
      check({tag, " cout held"}, cout, v.exp_cout);
      extra = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) extra++;
      end
      check({tag, " extra done"}, extra, 0);
      check({tag, " sum idle"}, sum, v.exp_sum);
   endtask

   initial begin
      vec_t vecs[8];
      vec_t v;
      int   dcnt;
      int   last_done;
      int   gap;

      vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sub: 1'b0, exp_sum: 8'h00, exp_cout: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
      vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sub: 1'b0, exp_sum: 8'h80, exp_cout: 1'b0};
      vecs[3] = '{a: 8'h12, b: 8'h34, cin: 1'b0, sub: 1'b0, exp_sum: 8'h46, exp_cout: 1'b0};
      vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b1, sub: 1'b0, exp_sum: 8'h01, exp_cout: 1'b1};
      vecs[5] = '{a: 8'h0F, b: 8'hF0, cin: 1'b0, sub: 1'b0, exp_sum: 8'hFF, exp_cout: 1'b0};
      vecs[6] = '{a: 8'h3C, b: 8'h55, cin: 1'b1, sub: 1'b0, exp_sum: 8'h92, exp_cout: 1'b0};
      vecs[7] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sub: 1'b0, exp_sum: 8'hFF, exp_cout: 1'b1};

      rst_n = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b0;
`endif
      #2 rst_n = 1'b0;
      #1;
      check("reset sum", sum, 0);
      check("reset cout", cout, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i], 0, 1'b0, $sformatf("vec%0d", i));
      end

      // start re-pulsed mid-RUN must not disturb the running addition
      v = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, sub: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
      run_op(v, 3, 1'b0, "repulse");

      // Reset during RUN cycle 4 (previous result has cout=1, sum=00; running
      // FF+00 has built up non-zero partial sum bits).
      @(negedge clk);
      a = 8'hFF; b = 8'h00; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("midrun busy before reset", busy, 1);
      check("midrun partial sum", sum, 8'hE0);
      rst_n = 1'b0;
      #1;
      check("midrun reset sum", sum, 0);
      check("midrun reset cout", cout, 0);
      check("midrun reset busy", busy, 0);
      check("midrun reset done", done, 0);
      dcnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      check("reset held quiet", dcnt, 0);
      rst_n = 1'b1;
      v = '{a: 8'h03, b: 8'h04, cin: 1'b0, sub: 1'b0, exp_sum: 8'h07, exp_cout: 1'b0};
      run_op(v, 0, 1'b1, "after reset");

      // start held high: new operation every 10 cycles
      @(negedge clk);
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      dcnt      = 0;
      last_done = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) begin
            dcnt++;
            check($sformatf("b2b sum #%0d", dcnt), sum, 8'h30);
            check($sformatf("b2b cout #%0d", dcnt), cout, 0);
            if (last_done >= 0) begin
               gap = i - last_done;
               check($sformatf("b2b spacing #%0d", dcnt), gap, 10);
            end else begin
               check("b2b first done edge", i, 8);
            end
            last_done = i;
         end
      end
      start = 1'b0;
      check("b2b pulse count", dcnt, 3);
      repeat (3) @(negedge clk);
      check("b2b idle after", busy, 0);

`ifdef SERIAL_ADDER_SUB_EN
      v = '{a: 8'h05, b: 8'h07, cin: 1'b0, sub: 1'b1, exp_sum: 8'hFE, exp_cout: 1'b0};
      run_op(v, 0, 1'b0, "sub 05-07");
      v = '{a: 8'h07, b: 8'h05, cin: 1'b0, sub: 1'b1, exp_sum: 8'h02, exp_cout: 1'b1};
      run_op(v, 0, 1'b0, "sub 07-05");
      v = '{a: 8'h07, b: 8'h05, cin: 1'b1, sub: 1'b0, exp_sum: 8'h0D, exp_cout: 1'b0};
      run_op(v, 0, 1'b0, "sub off add");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: operand A; captured on the accepted start.
REQ-006 SHALL have port b, input, WIDTH bits: operand B; captured on the accepted start.
REQ-007 SHALL have port cin, input, 1 bit: initial carry; captured on the accepted start.
REQ-008 SHALL have port sum, output, WIDTH bits: the registered result.
REQ-009 SHALL have port cout, output, 1 bit: the registered final carry.
REQ-010 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-012 SHALL compute the sum with exactly one 1-bit full-adder slice, reused every cycle: s = x^y^c; co = (x&y)|(c&(x^y)).
REQ-013 SHALL implement a state machine with states IDLE, RUN and DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after WIDTH bit-cycles.
- DONE -> IDLE unconditionally after one cycle.
REQ-014 On the IDLE cycle where start=1, the block SHALL:
- load a and b into internal shift registers;
- load cin into the carry flop;
- clear the bit counter to 0;
- clear sum to 0.
REQ-015 Each RUN cycle SHALL perform these steps:
- feed the operand LSBs and the carry flop into the slice;
- shift the sum register right one place, inserting s at bit WIDTH-1;
- shift both operand registers right one place;
- store co in the carry flop;
- increment the counter.
REQ-016 RUN SHALL last exactly WIDTH cycles, from counter value 0 to WIDTH-1; on the cycle with counter=WIDTH-1 the next state SHALL be DONE.
REQ-017 In DONE the block SHALL:
- drive done=1 for exactly one cycle;
- present sum equal to (a+b+cin) mod 2^WIDTH;
- present cout equal to bit WIDTH of a+b+cin.
REQ-018 The latency from the start-sampling edge to the edge that sets done SHALL be WIDTH+1 cycles.
REQ-019 busy SHALL be 1 exactly in RUN and 0 in IDLE and DONE.
REQ-020 start in RUN or DONE SHALL be ignored; there is no queuing, and a, b and cin are don't-care there.
REQ-021 sum and cout SHALL hold their DONE values through DONE and IDLE until the next accepted start.
REQ-022 During RUN, sum SHALL show intermediate shift contents; it is valid only when done=1 or after done in IDLE.
REQ-023 Back-to-back operations: start held high continuously SHALL begin a new operation every WIDTH+2 cycles.

Reset
REQ-024 When rst_n=0, the block SHALL immediately, regardless of clock, set state=IDLE, sum=0, cout=0, busy=0, done=0, counter=0, carry flop=0 and operand registers=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after deassertion the block SHALL accept start in the first clock edge's IDLE.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN:
- When defined, the block SHALL add a 1-bit input port sub, captured on the accepted start.
- When the captured sub=1, the block SHALL load ~b and force the initial carry to 1 (cin ignored), computing a-b; cout=1 means no borrow.
- When sub=0, the block SHALL add as in REQ-017.
- When the macro is undefined, the sub port SHALL be absent and the block SHALL always add.

Verification (WIDTH=8)
REQ-027 The bench SHALL cover these directed scenarios:
- a=8'h00, b=8'h00, cin=0, start pulse -> done on 9th edge, sum=8'h00, cout=0, busy high for 8 cycles.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0.
- a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; with start re-pulsed mid-RUN using a=8'h11, the result is unchanged and there is exactly one done pulse.
- rst_n low at RUN cycle 4 -> all outputs 0 at once, no done; then a=8'h03, b=8'h04, cin=0 -> sum=8'h07, cout=0.
- start held high for 30 cycles with a=8'h10, b=8'h20 -> done pulses spaced 10 cycles apart, each with sum=8'h30.
- SERIAL_ADDER_SUB_EN defined: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0; a=8'h07, b=8'h05, sub=1 -> sum=8'h02, cout=1.
